// File: rtl/uart_flowctl_pkg.sv
// ============================================================================
// uart_flowctl_pkg : pin polarities, default parameters and TX FSM encoding
// Revision 1.0
// ============================================================================
`default_nettype none

package uart_flowctl_pkg;

    localparam logic c_CTS_PIN_CLEAR  = 1'b0;
    localparam logic c_CTS_PIN_BLOCK  = 1'b1;
    localparam logic c_RTS_PIN_ACCEPT = 1'b0;
    localparam logic c_RTS_PIN_HOLD   = 1'b1;

    localparam int c_RXFIFO_DEPTH_BITS_DEF = 4;
    localparam int c_RTS_HIGH_WM_DEF       = 12;
    localparam int c_RTS_LOW_WM_DEF        = 4;
    localparam int c_TIMEOUT_TICKS_DEF     = 640;
    localparam int c_CTS_FILTER_SAMPLES    = 3;

    typedef enum logic [0:0] {
        TX_RUN   = 1'b0,
        TX_STALL = 1'b1
    } tx_state_e;

    // Idle counter must hold TIMEOUT_TICKS and never shrink below 10 bits.
    function automatic int timeout_cnt_width(input int ticks);
        int w;
        w = $clog2(ticks + 1);
        return (w < 10) ? 10 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_flowctl_if.sv
// ============================================================================
// uart_flowctl_if : TX FIFO / transmitter / RX FIFO handshake bundle
// Revision 1.0
// ============================================================================
`default_nettype none

interface uart_flowctl_if
    import uart_flowctl_pkg::*;
#(
    parameter int RXFIFO_DEPTH_BITS = c_RXFIFO_DEPTH_BITS_DEF
);
    logic                       txf_empty_i;
    logic [7:0]                 txf_byte_i;
    logic                       txf_deq_o;
    logic [7:0]                 tx_byte_o;
    logic                       tx_en_o;
    logic                       tx_ready_i;
    logic [RXFIFO_DEPTH_BITS:0] rxf_count_i;
    logic                       rx_en_i;
    logic                       rxf_deq_i;

    modport slave (
        input  txf_empty_i, txf_byte_i, tx_ready_i, rxf_count_i, rx_en_i, rxf_deq_i,
        output txf_deq_o, tx_byte_o, tx_en_o
    );

    modport master (
        output txf_empty_i, txf_byte_i, tx_ready_i, rxf_count_i, rx_en_i, rxf_deq_i,
        input  txf_deq_o, tx_byte_o, tx_en_o
    );

endinterface

`default_nettype wire

// File: rtl/uart_flowctl_sync_glitch_filter.sv
// ============================================================================
// sync_glitch_filter : 2-flop synchronizer followed by an N-sample agreement filter
// Revision 1.0
// ============================================================================
`default_nettype none

module sync_glitch_filter #(
    parameter int   SAMPLES = 3,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_async,
    output logic o_level
);

    logic [1:0]         r_sync;
    logic [SAMPLES-2:0] r_hist;
    logic               r_level;
    logic [SAMPLES-1:0] w_window;

    // Window = current synchronized sample plus the SAMPLES-1 before it.
    assign w_window = {r_hist, r_sync[1]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sync  <= {2{RST_VAL}};
            r_level <= RST_VAL;
        end else begin
            r_sync <= {r_sync[0], i_async};
            if (&w_window) begin
                r_level <= 1'b1;
            end else if (~|w_window) begin
                r_level <= 1'b0;
            end
        end
    end

    generate
        if (SAMPLES > 2) begin : g_hist_long
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_hist <= {(SAMPLES-1){RST_VAL}};
                end else begin
                    r_hist <= {r_hist[SAMPLES-3:0], r_sync[1]};
                end
            end
        end else begin : g_hist_short
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_hist <= RST_VAL;
                end else begin
                    r_hist <= r_sync[1];
                end
            end
        end
    endgenerate

    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/uart_flowctl.sv
// ============================================================================
// uart_flowctl : UART RTS/CTS hardware flow control and RX idle timeout
// Revision 1.0
// ============================================================================
`default_nettype none

module uart_flowctl
    import uart_flowctl_pkg::*;
#(
    parameter int RXFIFO_DEPTH_BITS = c_RXFIFO_DEPTH_BITS_DEF,
    parameter int RTS_HIGH_WM       = c_RTS_HIGH_WM_DEF,
    parameter int RTS_LOW_WM        = c_RTS_LOW_WM_DEF,
    parameter int TIMEOUT_TICKS     = c_TIMEOUT_TICKS_DEF
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           uart_cken_i,
    input  logic           ena_hwflow_i,
    input  logic           cts_pin_i,
    output logic           rts_pin_o,
    output logic           cts_o,
    output logic           tx_stall_o,
    output logic           rx_timeout_o,
    uart_flowctl_if.slave  bus
);

    localparam int              c_CW      = RXFIFO_DEPTH_BITS + 1;
    localparam int              c_TW      = timeout_cnt_width(TIMEOUT_TICKS);
    localparam logic [c_CW-1:0] c_HIGH_WM = c_CW'(RTS_HIGH_WM);
    localparam logic [c_CW-1:0] c_LOW_WM  = c_CW'(RTS_LOW_WM);
    localparam logic [c_TW-1:0] c_TO_MAX  = c_TW'(TIMEOUT_TICKS);

    logic            w_cts_level;
    logic            w_tx_en;
    logic            w_hold_off;
    tx_state_e       r_tx_state;
    tx_state_e       w_tx_state_nxt;
    logic            r_rts;
    logic [c_CW-1:0] w_count;
    logic            w_rx_activity;
    logic            w_rx_empty;
    logic            w_idle_full;
    logic [c_TW-1:0] r_idle_cnt;
    logic            r_rx_timeout;

    // ---------------- CTS input conditioning ----------------
    sync_glitch_filter #(
        .SAMPLES (c_CTS_FILTER_SAMPLES),
        .RST_VAL (c_CTS_PIN_BLOCK)
    ) u_cts_filter (
        .clk     (clk),
        .resetn  (resetn),
        .i_async (cts_pin_i),
        .o_level (w_cts_level)
    );

    assign cts_o = (w_cts_level == c_CTS_PIN_CLEAR);

    // ---------------- TX handoff ----------------
    // CTS only gates the next handoff; a byte already taken by the transmitter is its own.
    assign w_tx_en       = !bus.txf_empty_i && (!ena_hwflow_i || cts_o);
    assign bus.tx_en_o   = w_tx_en;
    assign bus.tx_byte_o = bus.txf_byte_i;
    assign bus.txf_deq_o = resetn && w_tx_en && bus.tx_ready_i;

    assign w_hold_off = ena_hwflow_i && !cts_o && !bus.txf_empty_i;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx_state <= TX_RUN;
        end else begin
            r_tx_state <= w_tx_state_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        case (r_tx_state)
            TX_RUN: begin
                if (w_hold_off) begin
                    w_tx_state_nxt = TX_STALL;
                end
            end
            TX_STALL: begin
                if (!w_hold_off) begin
                    w_tx_state_nxt = TX_RUN;
                end
            end
            default: begin
                w_tx_state_nxt = TX_RUN;
            end
        endcase
    end

    assign tx_stall_o = (r_tx_state == TX_STALL);

    // ---------------- RTS with watermark hysteresis ----------------
    assign w_count = bus.rxf_count_i;

    always_ff @(posedge clk) begin
        if (!resetn || !ena_hwflow_i) begin
            r_rts <= c_RTS_PIN_ACCEPT;
        end else if (w_count >= c_HIGH_WM) begin
            r_rts <= c_RTS_PIN_HOLD;
        end else if (w_count <= c_LOW_WM) begin
            r_rts <= c_RTS_PIN_ACCEPT;
        end
    end

    assign rts_pin_o = r_rts;

    // ---------------- RX idle timeout ----------------
    assign w_rx_activity = bus.rx_en_i || bus.rxf_deq_i;
    assign w_rx_empty    = (w_count == '0);
    assign w_idle_full   = (r_idle_cnt == c_TO_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idle_cnt <= '0;
        end else if (w_rx_activity || w_rx_empty) begin
            r_idle_cnt <= '0;
        end else if (uart_cken_i && !w_idle_full) begin
            r_idle_cnt <= r_idle_cnt + c_TW'(1);
        end
    end

    // Activity clears the flag even if the counter saturates in the same cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_timeout <= 1'b0;
        end else if (w_rx_activity) begin
            r_rx_timeout <= 1'b0;
        end else if (w_idle_full && !w_rx_empty) begin
            r_rx_timeout <= 1'b1;
        end
    end

    assign rx_timeout_o = r_rx_timeout;

endmodule

`default_nettype wire

// File: tb/tb_uart_flowctl.sv
// ============================================================================
// tb_uart_flowctl : directed + randomized self-checking bench for uart_flowctl
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_uart_flowctl;

    localparam int DB      = 4;
    localparam int TO_MAX  = 640;
    localparam int HIGH_WM = 12;
    localparam int LOW_WM  = 4;

    logic clk          = 1'b0;
    logic resetn       = 1'b0;
    logic uart_cken_i  = 1'b0;
    logic ena_hwflow_i = 1'b0;
    logic cts_pin_i    = 1'b1;
    logic rts_pin_o;
    logic cts_o;
    logic tx_stall_o;
    logic rx_timeout_o;

    uart_flowctl_if #(.RXFIFO_DEPTH_BITS(DB)) bus ();

    uart_flowctl #(.RXFIFO_DEPTH_BITS(DB)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_cken_i  (uart_cken_i),
        .ena_hwflow_i (ena_hwflow_i),
        .cts_pin_i    (cts_pin_i),
        .rts_pin_o    (rts_pin_o),
        .cts_o        (cts_o),
        .tx_stall_o   (tx_stall_o),
        .rx_timeout_o (rx_timeout_o),
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Environment / reference model state
    logic [7:0] txq[$];
    logic [7:0] got[$];
    logic       pins[$];
    int   rcount = 0;
    int   n_deq  = 0;
    logic cts_hi_seen = 1'b0;
    logic m_lvl   = 1'b1;
    logic m_stall = 1'b0;
    logic m_rts   = 1'b0;
    logic m_to    = 1'b0;
    int   m_idle  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO-side inputs, check combinational outputs, advance the
    // model over the edge, then check registered outputs on the falling edge.
    task automatic tick();
        logic exp_en, exp_deq, nx_stall;
        bus.txf_empty_i = (txq.size() == 0);
        bus.txf_byte_i  = (txq.size() == 0) ? 8'h00 : txq[0];
        bus.rxf_count_i = (DB+1)'(rcount);
        #1;
        exp_en  = (txq.size() != 0) && (!ena_hwflow_i || !m_lvl);
        exp_deq = exp_en && bus.tx_ready_i && resetn;
        chk("tx_en", bus.tx_en_o, exp_en);
        chk("txf_deq", bus.txf_deq_o, exp_deq);
        chk("tx_byte", bus.tx_byte_o, bus.txf_byte_i);
        if (bus.txf_deq_o === 1'b1) begin
            n_deq++;
            got.push_back(bus.tx_byte_o);
        end
        @(posedge clk);
        if (!resetn) begin
            pins    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            m_lvl   = 1'b1;
            m_stall = 1'b0;
            m_rts   = 1'b0;
            m_idle  = 0;
            m_to    = 1'b0;
        end else begin
            nx_stall = ena_hwflow_i && m_lvl && (txq.size() != 0);
            if (bus.rx_en_i || bus.rxf_deq_i) m_to = 1'b0;
            else if (m_idle == TO_MAX && rcount > 0) m_to = 1'b1;
            if (bus.rx_en_i || bus.rxf_deq_i || rcount == 0) m_idle = 0;
            else if (uart_cken_i && m_idle < TO_MAX) m_idle++;
            if (!ena_hwflow_i) m_rts = 1'b0;
            else if (rcount >= HIGH_WM) m_rts = 1'b1;
            else if (rcount <= LOW_WM) m_rts = 1'b0;
            // Pin level counts once seen 3 cycles in a row, 2 cycles late.
            pins.push_front(cts_pin_i);
            if (pins[2] == pins[3] && pins[3] == pins[4]) m_lvl = pins[2];
            void'(pins.pop_back());
            m_stall = nx_stall;
        end
        if (exp_deq) void'(txq.pop_front());
        rcount = rcount + int'(bus.rx_en_i) - int'(bus.rxf_deq_i);
        @(negedge clk);
        chk("cts_o", cts_o, !m_lvl);
        chk("tx_stall", tx_stall_o, m_stall);
        chk("rts_pin", rts_pin_o, m_rts);
        chk("rx_timeout", rx_timeout_o, m_to);
        if (cts_o === 1'b1) cts_hi_seen = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        pins = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        bus.txf_empty_i = 1'b1;
        bus.txf_byte_i  = 8'h00;
        bus.tx_ready_i  = 1'b1;
        bus.rxf_count_i = '0;
        bus.rx_en_i     = 1'b0;
        bus.rxf_deq_i   = 1'b0;

        // Reset with a byte pending and flow control off: no dequeue allowed.
        resetn = 1'b0;
        cts_pin_i = 1'b0;
        txq.push_back(8'hEE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        repeat (3) tick();
        chk("rst_cts", cts_o, 1'b0);
        chk("rst_stall", tx_stall_o, 1'b0);
        chk("rst_rts", rts_pin_o, 1'b0);
        chk("rst_timeout", rx_timeout_o, 1'b0);
        chk("rst_deq_cnt", n_deq, 0);

        // Flow control off: three bytes leave back to back.
        resetn = 1'b1;
        cts_pin_i = 1'b1;
        txq.delete();
        txq.push_back(8'h3C); txq.push_back(8'hC3); txq.push_back(8'h5A);
        n_deq = 0;
        got.delete();
        repeat (8) tick();
        chk("noflow_deq_cnt", n_deq, 3);
        chk("noflow_byte0", got[0], 8'h3C);
        chk("noflow_byte1", got[1], 8'hC3);
        chk("noflow_byte2", got[2], 8'h5A);
        chk("noflow_rts", rts_pin_o, 1'b0);

        // Flow control on, peer blocking: stall, then release after 5 clk.
        ena_hwflow_i = 1'b1;
        txq.push_back(8'h77); txq.push_back(8'h88);
        tick();
        chk("hold_stall", tx_stall_o, 1'b1);
        chk("hold_tx_en", bus.tx_en_o, 1'b0);
        cts_pin_i = 1'b0;
        bus.tx_ready_i = 1'b0;
        repeat (4) tick();
        chk("cts_lat4", cts_o, 1'b0);
        tick();
        chk("cts_lat5", cts_o, 1'b1);
        bus.tx_ready_i = 1'b1;
        n_deq = 0;
        got.delete();
        tick();
        chk("release_deq_cnt", n_deq, 1);
        chk("release_byte", got[0], 8'h77);

        // 2-clk CTS glitch must be rejected.
        bus.tx_ready_i = 1'b0;
        cts_pin_i = 1'b1;
        repeat (6) tick();
        chk("glitch_pre_cts", cts_o, 1'b0);
        bus.tx_ready_i = 1'b1;
        n_deq = 0;
        cts_hi_seen = 1'b0;
        cts_pin_i = 1'b0;
        repeat (2) tick();
        cts_pin_i = 1'b1;
        repeat (8) tick();
        chk("glitch_cts_seen", cts_hi_seen, 1'b0);
        chk("glitch_deq_cnt", n_deq, 0);

        // RTS hysteresis: fill to 12, drain to 5 (hold), then 4 (release).
        bus.rx_en_i = 1'b1;
        repeat (12) tick();
        bus.rx_en_i = 1'b0;
        tick();
        chk("rts_at12", rts_pin_o, 1'b1);
        bus.rxf_deq_i = 1'b1;
        repeat (7) tick();
        bus.rxf_deq_i = 1'b0;
        tick();
        chk("rts_at5", rts_pin_o, 1'b1);
        bus.rxf_deq_i = 1'b1;
        tick();
        bus.rxf_deq_i = 1'b0;
        tick();
        chk("rts_at4", rts_pin_o, 1'b0);

        // RX idle timeout with one byte left.
        bus.rxf_deq_i = 1'b1;
        repeat (3) tick();
        bus.rxf_deq_i = 1'b0;
        chk("to_count1", rcount, 1);
        for (int i = 0; i < TO_MAX - 1; i++) begin
            uart_cken_i = 1'b1; tick();
            uart_cken_i = 1'b0; tick();
        end
        chk("to_before", rx_timeout_o, 1'b0);
        uart_cken_i = 1'b1; tick();
        uart_cken_i = 1'b0;
        chk("to_reach", rx_timeout_o, 1'b0);
        tick();
        chk("to_set", rx_timeout_o, 1'b1);
        bus.rxf_deq_i = 1'b1;
        tick();
        bus.rxf_deq_i = 1'b0;
        chk("to_clear", rx_timeout_o, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 6 == 0)  cts_pin_i = ~cts_pin_i;
            if ($urandom % 50 == 0) ena_hwflow_i = ~ena_hwflow_i;
            bus.tx_ready_i = ($urandom % 3 != 0);
            bus.rx_en_i    = ($urandom % 4 == 0) && (rcount < 16);
            bus.rxf_deq_i  = ($urandom % 4 == 0) && (rcount > 0);
            uart_cken_i    = ($urandom % 16 == 0);
            if (txq.size() < 4 && $urandom % 3 == 0) txq.push_back(8'($urandom));
            tick();
        end

        // Reset in the middle of hwflow traffic.
        ena_hwflow_i = 1'b1;
        cts_pin_i = 1'b0;
        uart_cken_i = 1'b0;
        bus.rx_en_i = 1'b0;
        bus.rxf_deq_i = 1'b0;
        bus.tx_ready_i = 1'b0;
        repeat (6) tick();
        for (int i = 0; i < 20 && rcount < 13; i++) begin
            bus.rx_en_i = 1'b1;
            tick();
        end
        bus.rx_en_i = 1'b0;
        tick();
        chk("pre_rst_rts", rts_pin_o, 1'b1);
        chk("pre_rst_cts", cts_o, 1'b1);
        txq.push_back(8'h12); txq.push_back(8'h34); txq.push_back(8'h56);
        bus.tx_ready_i = 1'b1;
        tick();
        resetn = 1'b0;
        tick();
        chk("midrst_cts", cts_o, 1'b0);
        chk("midrst_stall", tx_stall_o, 1'b0);
        chk("midrst_rts", rts_pin_o, 1'b0);
        chk("midrst_timeout", rx_timeout_o, 1'b0);
        chk("midrst_deq", bus.txf_deq_o, 1'b0);
        resetn = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_flowctl.md
UART_FLOWCTL -- requirements
Module: uart_flowctl

Interface
REQ-001 Parameter RXFIFO_DEPTH_BITS, default 4, RX FIFO holds 2**RXFIFO_DEPTH_BITS bytes.
REQ-002 Parameter RTS_HIGH_WM, default 12, RX fill level at which RTS is deasserted.
REQ-003 Parameter RTS_LOW_WM, default 4, RX fill level at which RTS is re-asserted; SHALL be < RTS_HIGH_WM.
REQ-004 Parameter TIMEOUT_TICKS, default 640 (4 char times at 16x), RX idle timeout in uart_cken_i ticks.
REQ-005 clk  in  1  system clock, 48MHz.
REQ-006 resetn  in  1  reset; synchronous, active-low; clock clk.
REQ-007 uart_cken_i  in  1  16x baud tick, 1T pulse.
REQ-008 ena_hwflow_i  in  1  1 = RTS/CTS flow control enabled.
REQ-009 cts_pin_i  in  1  asynchronous CTS pin, active-low (0 = peer accepts data).
REQ-010 rts_pin_o  out  1  RTS pin, active-low (0 = we accept data).
REQ-011 txf_empty_i  in  1  TX FIFO empty.
REQ-012 txf_byte_i  in  8  TX FIFO head byte.
REQ-013 txf_deq_o  out  1  TX FIFO dequeue, 1T.
REQ-014 tx_byte_o  out  8  byte to transmitter.
REQ-015 tx_en_o  out  1  transmit request to transmitter.
REQ-016 tx_ready_i  in  1  transmitter can accept a byte.
REQ-017 rxf_count_i  in  RXFIFO_DEPTH_BITS+1  RX FIFO occupancy.
REQ-018 rx_en_i  in  1  byte received pulse (RX FIFO enqueue).
REQ-019 rxf_deq_i  in  1  RX FIFO dequeue pulse by CPU.
REQ-020 cts_o  out  1  filtered CTS level, 1 = clear to send (status bit).
REQ-021 tx_stall_o  out  1  1 while TX is held off by CTS.
REQ-022 rx_timeout_o  out  1  sticky RX idle-timeout flag.

Function
REQ-023 CTS path: 2-flop synchronizer, then glitch filter; cts_o changes only after 3 consecutive equal synchronized samples; latency pin->cts_o = 5 clk.
REQ-024 TX FSM states RUN, STALL; RUN->STALL when ena_hwflow_i=1, cts_o=0, txf_empty_i=0; STALL->RUN when cts_o=1 or ena_hwflow_i=0 or txf_empty_i=1.
REQ-025 tx_en_o = !txf_empty_i && (!ena_hwflow_i || cts_o); tx_byte_o = txf_byte_i (combinational pass-through).
REQ-026 txf_deq_o = tx_en_o && tx_ready_i; exactly one dequeue per byte handed to transmitter.
REQ-027 A byte already accepted by the transmitter SHALL complete; CTS deassertion only blocks the next handoff.
REQ-028 tx_stall_o = 1 iff FSM in STALL.
REQ-029 RTS: registered; ena_hwflow_i=0 -> rts_pin_o=0; else set to 1 when rxf_count_i >= RTS_HIGH_WM, cleared to 0 when rxf_count_i <= RTS_LOW_WM, otherwise hold (hysteresis); update 1 clk after count change.
REQ-030 Timeout counter: 10-bit minimum width, cleared on rx_en_i, rxf_deq_i, or rxf_count_i=0; increments on uart_cken_i otherwise; saturates at TIMEOUT_TICKS.
REQ-031 rx_timeout_o set the clk after counter reaches TIMEOUT_TICKS with rxf_count_i>0; cleared on rxf_deq_i or rx_en_i; clear wins over set in the same cycle.
REQ-032 ena_hwflow_i toggled mid-byte SHALL NOT corrupt an in-flight byte; takes effect at next handoff.

Reset
REQ-033 During resetn=0: synchronizer and filter flops = 1 (cts_o=0), FSM=RUN, rts_pin_o=0, timeout counter=0, rx_timeout_o=0.
REQ-034 txf_deq_o SHALL be 0 during reset regardless of inputs.

Structure
REQ-035 Shared package holds pin polarity constants, default watermarks, TIMEOUT_TICKS default, FSM state encoding.
REQ-036 One sub-module: sync_glitch_filter (2-flop sync + N-sample filter, reset value parameter).

Verification
REQ-037 ena_hwflow=0, cts_pin=1, 3 bytes in TX FIFO -> 3 txf_deq pulses, rts_pin_o=0 throughout.
REQ-038 ena_hwflow=1, cts_pin=1 -> tx_en_o=0, tx_stall_o=1; cts_pin->0 -> cts_o=1 after 5 clk, first deq next ready.
REQ-039 CTS pulse low for 2 clk -> cts_o stays 0, no dequeue.
REQ-040 rxf_count 0->12 -> rts_pin_o=1; drain to 5 -> stays 1; at 4 -> rts_pin_o=0.
REQ-041 1 byte in RX FIFO, 640 cken ticks idle -> rx_timeout_o=1; rxf_deq_i -> 0 next clk.
REQ-042 resetn=0 mid-transmission with hwflow on -> all outputs at REQ-033 values next clk.
